// File: rtl/unsignandsign_divider.sv
// Restoring 16-by-8 divider for unsigned and two's-complement operands.
// One quotient bit per clock behind a start/busy/done handshake.
module unsignandsign_divider #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH_N);
    localparam logic [CW-1:0] LAST = CW'(WIDTH_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH_N-1:0] num_q, num_d;
    logic [WIDTH_D-1:0] den_q, den_d;
    logic [WIDTH_D-1:0] part_q, part_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH_N-1:0] quo_q, quo_d;
    logic [WIDTH_D-1:0] rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic               dvd_neg;
    logic               dvs_neg;
    logic [WIDTH_N-1:0] dvd_mag;
    logic [WIDTH_D-1:0] dvs_mag;
    logic [WIDTH_D:0]   shifted;
    logic               fits;
    logic [WIDTH_D-1:0] trial;
    logic [WIDTH_D-1:0] part_nx;
    logic [WIDTH_N-1:0] num_nx;

    // Operand magnitudes; a wrapped -min stays correct as an unsigned value
    always_comb begin
        dvd_neg = sgn & dividend[WIDTH_N-1];
        dvs_neg = sgn & divisor[WIDTH_D-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
    end

    // One restoring step: 9-bit trial against the divisor magnitude
    always_comb begin
        shifted = {part_q, num_q[WIDTH_N-1]};
        fits    = shifted >= {1'b0, den_q};
        trial   = shifted[WIDTH_D-1:0] - den_q;
        part_nx = fits ? trial : shifted[WIDTH_D-1:0];
        num_nx  = {num_q[WIDTH_N-2:0], fits};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        den_d   = den_q;
        part_d  = part_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    num_d  = dvd_mag;
                    den_d  = dvs_mag;
                    part_d = '0;
                    cnt_d  = '0;
                    qneg_d = dvd_neg ^ dvs_neg;
                    rneg_d = dvd_neg;
                    if (divisor == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quo_d   = '1;
                        rem_d   = dividend[WIDTH_D-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                num_d  = num_nx;
                part_d = part_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = qneg_q ? -num_nx : num_nx;
                    rem_d   = rneg_q ? -part_nx : part_nx;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            part_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            den_q   <= den_d;
            part_q  <= part_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
